fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences instruction fetch against a variable-latency instruction memory with a request/ready/response handshake. Owns the program counter and keeps at most one memory request outstanding. Buffers returned instructions in a 2-entry queue toward decode, and discards stale responses after a branch or pipeline redirect. Sits between the instruction memory port and the decode stage.

Parameters:
BOOT_ADDRESS, 32'h0000_0000, PC value loaded at reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
im_req  output  1  memory request valid.
im_addr  output  30  word address, equal to fetch PC[31:2].
im_ready  input  1  memory accepts the request this cycle (im_req && im_ready).
im_rvalid  input  1  response valid; 1 or more cycles after acceptance.
im_rdata  input  32  response instruction word.
branch_d  input  1  redirect from decode.
branch_next_addr_d  input  32  branch target.
pc_write_m  input  1  redirect from memory stage; has priority over branch_d.
pc_next_addr_m  input  32  redirect target.
stall_d  input  1  decode cannot accept an instruction this cycle.
valid_f  output  1  instruction_f/pc_f valid toward decode.
instruction_f  output  32  head-of-queue instruction.
pc_f  output  32  byte PC of instruction_f.
busy_f  output  1  request outstanding (WAIT or KILL state).

Behaviour:
- Reset (asynchronous, active-high):
  - fetch PC = BOOT_ADDRESS; state = REQ; queue empty.
  - im_req = 0, valid_f = 0, busy_f = 0.
  - instruction_f and pc_f read 0 while the queue is empty.
- redirect = pc_write_m | branch_d. Target is pc_next_addr_m if pc_write_m, otherwise branch_next_addr_d. Target bits [1:0] are forced to 0.
- Slot accounting: space = (queue_count + outstanding) < 2, where outstanding = 1 in WAIT or KILL.
- FSM states: REQ, WAIT, KILL.
- REQ:
  - im_req = space && !redirect.
  - On accept: latch req_pc = PC, set PC = PC + 4 (mod 2^32, wrap from 0xFFFF_FFFC to 0), go to WAIT.
  - im_rvalid in REQ is ignored.
- WAIT:
  - im_req = 0.
  - On im_rvalid without redirect: push {req_pc, im_rdata}, go to REQ.
  - On im_rvalid with redirect: drop the data, go to REQ.
  - On redirect without im_rvalid: go to KILL.
- KILL:
  - im_req = 0.
  - On im_rvalid: drop the data, go to REQ.
  - A redirect in KILL updates PC and remains in KILL.
- Redirect in any state:
  - PC = target on the next edge.
  - Queue flushed (count = 0).
  - valid_f masked to 0 in the redirect cycle.
  - No request is issued in the redirect cycle.
- Queue: 2-entry FIFO of {pc, instruction}.
  - valid_f = !empty && !redirect.
  - Pop when valid_f && !stall_d.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Push never occurs when full, guaranteed by slot accounting.
- Latency:
  - Accept at cycle N with response at N+1 gives push at edge N+1 and valid_f at N+2.
  - Back-to-back fetch with single-cycle memory: one instruction every 2 cycles.
- No combinational path from im_rvalid/im_rdata to valid_f/instruction_f (registered queue).
- im_req depends combinationally on redirect; no path from stall_d to im_req except through queue_count.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding localparams S_REQ/S_WAIT/S_KILL (2 bits);
  - IM_AW = 30;
  - QUEUE_DEPTH = 2.
- One sub-module: fetch_queue, the 2-entry 64-bit FIFO with push, pop, flush, count, head_data.
- PC register, FSM and redirect mux stay in fetch_ctrl.

Test Plan:
1. Reset release, im_ready=1, 1-cycle response, stall_d=0 -> im_addr sequence 0x0, 0x1, 0x2; pc_f 0x0, 0x4, 0x8; valid_f pulses every 2 cycles.
2. stall_d held 1 for 10 cycles -> exactly 2 instructions queued; im_req stays 0 afterwards; on release, pc_f 0x0 then 0x4 pop on consecutive cycles.
3. Response delayed 3 cycles, branch_d=1 to 0x100 in the 2nd WAIT cycle -> state KILL, busy_f=1; stale im_rdata dropped; next im_addr = 0x40; next pc_f = 0x100.
4. pc_write_m=1 (0x200) and branch_d=1 (0x300) in the same cycle -> next fetch pc_f = 0x200; queue flushed; valid_f = 0 that cycle.
5. Redirect to 0x103 in the same cycle as im_rvalid in WAIT -> data dropped; fetch PC 0x100; no KILL state entered.
6. rst asserted mid-WAIT, then a stray im_rvalid after release -> ignored; im_addr = BOOT_ADDRESS>>2; valid_f stays 0 until the new response.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch controller.
//   S_REQ/S_WAIT/S_KILL : fetch FSM state encoding (2 bits)
//   IM_AW               : instruction memory word-address width
//   QUEUE_DEPTH         : fetch-to-decode buffer depth
//   fetch_entry_t       : one buffered {pc, instruction} pair
//   word_align()        : clears the byte-offset bits of an address
package fetch_pkg;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_KILL = 2'd2;

    localparam int IM_AW       = 30;
    localparam int QUEUE_DEPTH = 2;
    localparam int QCNT_W      = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of 64-bit {pc, instruction} entries.
//   clk, rst     : clock, asynchronous active-high reset
//   push, push_data : write an entry at the tail
//   pop          : drop the head entry
//   flush        : empty the queue (wins over push/pop)
//   count, empty : occupancy
//   head_data    : head entry, reads 0 while empty
module fetch_queue
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [63:0]       push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [QCNT_W-1:0] count,
    output logic              empty,
    output logic [63:0]       head_data
);

    logic [63:0]       entry0_q, entry0_d;
    logic [63:0]       entry1_q, entry1_d;
    logic [QCNT_W-1:0] count_q, count_d;

    // entry0 is always the head; a pop shifts entry1 forward.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (pop) begin
                entry0_d = entry1_q;
                count_d  = count_q - 1'b1;
            end
            if (push) begin
                if (count_d == '0) begin
                    entry0_d = push_data;
                end else begin
                    entry1_d = push_data;
                end
                count_d = count_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign head_data = empty ? 64'd0 : entry0_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer. Owns the fetch PC, keeps at most
// one memory request in flight and buffers responses toward decode.
//   clk, rst                     : clock, asynchronous active-high reset
//   im_req/im_addr/im_ready      : request handshake (word address)
//   im_rvalid/im_rdata           : response
//   branch_d/branch_next_addr_d  : redirect from decode
//   pc_write_m/pc_next_addr_m    : redirect from memory stage (higher priority)
//   stall_d                      : decode not accepting
//   valid_f/instruction_f/pc_f   : head of the fetch queue toward decode
//   busy_f                       : request outstanding
//
// state  | meaning
// S_REQ  | no request in flight; issue one when a queue slot is free
// S_WAIT | request accepted, response will be pushed to the queue
// S_KILL | request accepted but redirected; response will be dropped
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic             im_ready,
    input  logic             im_rvalid,
    input  logic [31:0]      im_rdata,
    input  logic             branch_d,
    input  logic [31:0]      branch_next_addr_d,
    input  logic             pc_write_m,
    input  logic [31:0]      pc_next_addr_m,
    input  logic             stall_d,
    output logic             valid_f,
    output logic [31:0]      instruction_f,
    output logic [31:0]      pc_f,
    output logic             busy_f
);

    logic [1:0]        state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       req_pc_q, req_pc_d;

    logic              redirect;
    logic [31:0]       redirect_target;
    logic              outstanding;
    logic              space;
    logic              accept;
    logic              push;
    logic              pop;
    logic              q_empty;
    logic [QCNT_W-1:0] q_count;
    logic [63:0]       q_head;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign redirect        = pc_write_m | branch_d;
    assign redirect_target = word_align(pc_write_m ? pc_next_addr_m : branch_next_addr_d);

    // An in-flight request reserves a queue slot so its response can
    // never find the queue full.
    assign outstanding = (state_q != S_REQ);
    assign space       = (int'(q_count) + int'(outstanding)) < QUEUE_DEPTH;

    assign im_req  = !rst && (state_q == S_REQ) && space && !redirect;
    assign accept  = im_req && im_ready;
    assign im_addr = pc_q[31:2];
    assign busy_f  = outstanding;

    assign push    = (state_q == S_WAIT) && im_rvalid && !redirect;
    assign valid_f = !q_empty && !redirect;
    assign pop     = valid_f && !stall_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (im_rvalid)     state_d = S_REQ;
                else if (redirect) state_d = S_KILL;
            end
            S_KILL: begin
                if (im_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= BOOT_ADDRESS;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign push_entry.pc    = req_pc_q;
    assign push_entry.instr = im_rdata;

    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (q_count),
        .empty     (q_empty),
        .head_data (q_head)
    );

    assign head_entry    = q_head;
    assign pc_f          = head_entry.pc;
    assign instruction_f = head_entry.instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl against a transaction-level
// model (PC, one in-flight request with a stale flag, and a queue of entries),
// driving a variable-latency memory model.
module tb_fetch_ctrl;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req;
    logic [29:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        branch_d;
    logic [31:0] branch_next_addr_d;
    logic        pc_write_m;
    logic [31:0] pc_next_addr_m;
    logic        stall_d;
    logic        valid_f;
    logic [31:0] instruction_f;
    logic [31:0] pc_f;
    logic        busy_f;

    always #5 clk = ~clk;

    fetch_ctrl #(.BOOT_ADDRESS(BOOT)) dut (
        .clk                (clk),
        .rst                (rst),
        .im_req             (im_req),
        .im_addr            (im_addr),
        .im_ready           (im_ready),
        .im_rvalid          (im_rvalid),
        .im_rdata           (im_rdata),
        .branch_d           (branch_d),
        .branch_next_addr_d (branch_next_addr_d),
        .pc_write_m         (pc_write_m),
        .pc_next_addr_m     (pc_next_addr_m),
        .stall_d            (stall_d),
        .valid_f            (valid_f),
        .instruction_f      (instruction_f),
        .pc_f               (pc_f),
        .busy_f             (busy_f)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // reference model
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_pending;
    bit          m_stale;
    ent_t        mq[$];

    // memory model
    bit          mem_busy;
    int          mem_lat;
    logic [29:0] mem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return ({a, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
        return $urandom & 32'h0000_0FFF;
    endfunction

    task automatic model_reset();
        m_pc      = BOOT;
        m_req_pc  = '0;
        m_pending = 0;
        m_stale   = 0;
        mq.delete();
    endtask

    // One clock cycle: drive after the rising edge, check at the falling
    // edge, advance the model at the next rising edge.
    task automatic cycle(input int p_redir, input int p_stall, input int p_ready,
                         input int max_lat, input bit do_rst);
        bit          redir, exp_req, exp_valid, acc, pop, push;
        logic [31:0] tgt, exp_pcf, exp_ins, old_pc;
        bit          mem_resp;

        rst                = do_rst;
        pc_write_m         = ($urandom_range(0, 99) < p_redir);
        branch_d           = ($urandom_range(0, 99) < p_redir);
        pc_next_addr_m     = rand_target();
        branch_next_addr_d = rand_target();
        stall_d            = ($urandom_range(0, 99) < p_stall);
        im_ready           = ($urandom_range(0, 99) < p_ready);
        mem_resp           = mem_busy && (mem_lat == 0);
        im_rvalid          = mem_resp || (!mem_busy && $urandom_range(0, 15) == 0);
        im_rdata           = mem_resp ? mem_word(mem_addr) : $urandom;
        if (do_rst) model_reset();

        @(negedge clk);
        redir     = !do_rst && (pc_write_m || branch_d);
        tgt       = (pc_write_m ? pc_next_addr_m : branch_next_addr_d) & 32'hFFFF_FFFC;
        exp_req   = !do_rst && !m_pending && (mq.size() < 2) && !redir;
        exp_valid = (mq.size() > 0) && !redir;
        exp_pcf   = (mq.size() > 0) ? mq[0].pc  : 32'd0;
        exp_ins   = (mq.size() > 0) ? mq[0].ins : 32'd0;

        chk("im_req",        {31'd0, im_req},  {31'd0, exp_req});
        chk("im_addr",       {2'b00, im_addr}, {2'b00, m_pc[31:2]});
        chk("busy_f",        {31'd0, busy_f},  {31'd0, m_pending});
        chk("valid_f",       {31'd0, valid_f}, {31'd0, exp_valid});
        chk("pc_f",          pc_f,             exp_pcf);
        chk("instruction_f", instruction_f,    exp_ins);

        @(posedge clk);
        old_pc = m_pc;
        acc    = exp_req && im_ready;
        pop    = exp_valid && !stall_d;
        push   = 0;
        if (!do_rst) begin
            if (im_rvalid && m_pending) begin
                push      = !m_stale && !redir;
                m_pending = 0;
                m_stale   = 0;
            end else if (m_pending && redir) begin
                m_stale = 1;
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{pc: m_req_pc, ins: im_rdata});
            if (redir) mq.delete();
            if (redir) begin
                m_pc = tgt;
            end else if (acc) begin
                m_req_pc  = m_pc;
                m_pc      = m_pc + 32'd4;
                m_pending = 1;
            end
        end
        if (mem_resp) mem_busy = 0;
        else if (mem_busy) mem_lat--;
        if (acc) begin
            mem_busy = 1;
            mem_addr = old_pc[31:2];
            mem_lat  = $urandom_range(0, max_lat);
        end
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        im_ready           = 1'b0;
        im_rvalid          = 1'b0;
        im_rdata           = '0;
        branch_d           = 1'b0;
        branch_next_addr_d = '0;
        pc_write_m         = 1'b0;
        pc_next_addr_m     = '0;
        stall_d            = 1'b0;
        mem_busy           = 0;
        mem_lat            = 0;
        mem_addr           = '0;
        model_reset();

        @(posedge clk);
        #1;
        repeat (2) cycle(0, 0, 100, 0, 1);

        // streaming with single-cycle memory and no stalls
        repeat (30) cycle(0, 0, 100, 0, 0);
        // decode stalled: queue fills, requests stop
        repeat (10) cycle(0, 100, 100, 0, 0);
        repeat (10) cycle(0, 0, 100, 0, 0);
        // slow memory with redirects
        repeat (300) cycle(6, 20, 80, 3, 0);
        // reset during an outstanding request, then stray response
        repeat (3) cycle(0, 0, 100, 3, 0);
        cycle(0, 0, 100, 3, 1);
        repeat (20) cycle(0, 0, 100, 3, 0);

        // mixed random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            case (i / 500)
                0:       cycle(8, 30, 70, 3, $urandom_range(0, 199) == 0);
                1:       cycle(2, 5, 100, 0, 0);
                2:       cycle(15, 50, 50, 4, $urandom_range(0, 149) == 0);
                3:       cycle(0, 70, 90, 1, 0);
                default: cycle(10, 20, 60, 2, $urandom_range(0, 249) == 0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
